// File: rtl/reorder_buffer_pkg.sv
// Shared types for the ROB slice: row/completion structs, index widths and the
// preg-release rule used at retire.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH    = 16;
    localparam int ROB_AW       = $clog2(ROB_DEPTH);
    localparam int ROB_ALLOC_W  = 2;
    localparam int ROB_CMPL_W   = 3;
    localparam int ROB_RETIRE_W = 2;
    localparam int PREG_W       = 6;
    localparam int WORD_W       = 32;

    typedef logic [PREG_W-1:0] p_reg;
    typedef logic [WORD_W-1:0] word;
    typedef logic [ROB_AW-1:0] rob_idx;

    typedef struct packed {
        logic   valid;
        logic   complete;
        rob_idx rob_number;
        logic   reg_write;
        logic   mem_write;
        p_reg   preg_dst;
        p_reg   old_preg_dst;
        word    data;
    } rob_row_struct;

    typedef struct packed {
        logic   valid;
        rob_idx rob;
        word    data;
    } rob_cmpl_struct;

    // Preg 0 is never handed back to the free list.
    function automatic logic frees_preg(input rob_row_struct row);
        return row.reg_write && (row.old_preg_dst != '0);
    endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Picks the in-order retire candidates starting at head: slot k retires only
// when every earlier slot retires and its own entry is valid and complete.
module rob_retire_select
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH    = ROB_DEPTH,
    parameter int RETIRE_W = ROB_RETIRE_W,
    parameter int RCNT_W   = $clog2(ROB_RETIRE_W + 1)
)(
    input  rob_idx                    head,
    input  logic [DEPTH-1:0]          valid,
    input  logic [DEPTH-1:0]          complete,
    output logic [RETIRE_W-1:0]       retire_en,
    output logic [RCNT_W-1:0]         retire_cnt,
    output rob_idx [RETIRE_W-1:0]     retire_idx
);

    logic [RETIRE_W-1:0] ready;

    generate
        for (genvar gi = 0; gi < RETIRE_W; gi++) begin : g_slot
            assign retire_idx[gi] = head + rob_idx'(gi);
            assign ready[gi]      = valid[retire_idx[gi]] & complete[retire_idx[gi]];
        end
    endgenerate

    always_comb begin
        logic run;
        retire_en  = '0;
        retire_cnt = '0;
        run        = 1'b1;
        for (int k = 0; k < RETIRE_W; k++) begin
            run          = run & ready[k];
            retire_en[k] = run;
            retire_cnt   = retire_cnt + RCNT_W'(run);
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit queue: allocates from dispatch, marks completions from the FU
// writeback ports, retires up to two complete rows per cycle from head.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH    = ROB_DEPTH,
    parameter int ALLOC_W  = ROB_ALLOC_W,
    parameter int CMPL_W   = ROB_CMPL_W,
    parameter int RETIRE_W = ROB_RETIRE_W
)(
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  rob_row_struct [0:ALLOC_W-1]   i_alloc_rows,
    output logic                          o_full,
    output logic                          o_empty,
    input  logic [0:CMPL_W-1]             i_cmpl_valid,
    input  rob_idx [0:CMPL_W-1]           i_cmpl_rob,
    input  word [0:CMPL_W-1]              i_cmpl_data,
    output rob_row_struct [0:RETIRE_W]    o_retire_rows,
    output logic [0:RETIRE_W-1]           o_free_preg_valid,
    output p_reg [0:RETIRE_W-1]           o_free_preg_addr,
    output logic                          o_err
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int RCNT_W = $clog2(RETIRE_W + 1);
    typedef logic [CNT_W-1:0] count_t;

    rob_row_struct               entry_reg [DEPTH];
    rob_row_struct               entry_next [DEPTH];
    rob_idx                      head_reg, head_next;
    rob_idx                      tail_reg, tail_next;
    count_t                      count_reg, count_next;
    logic                        full_reg, full_next;
    logic                        empty_reg, empty_next;
    logic                        err_reg, err_next;
    rob_row_struct [0:RETIRE_W]  retire_rows_reg, retire_rows_next;
    logic [0:RETIRE_W-1]         free_valid_reg, free_valid_next;
    p_reg [0:RETIRE_W-1]         free_addr_reg, free_addr_next;

    rob_cmpl_struct              cmpl [CMPL_W];
    logic [DEPTH-1:0]            valid_vec, complete_vec;
    logic [RETIRE_W-1:0]         retire_en;
    logic [RCNT_W-1:0]           retire_cnt;
    rob_idx [RETIRE_W-1:0]       retire_idx;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flags
            assign valid_vec[gi]    = entry_reg[gi].valid;
            assign complete_vec[gi] = entry_reg[gi].complete;
        end
        for (genvar gi = 0; gi < CMPL_W; gi++) begin : g_cmpl
            assign cmpl[gi] = '{valid: i_cmpl_valid[gi], rob: i_cmpl_rob[gi], data: i_cmpl_data[gi]};
        end
    endgenerate

    rob_retire_select #(
        .DEPTH    (DEPTH),
        .RETIRE_W (RETIRE_W),
        .RCNT_W   (RCNT_W)
    ) u_retire_select (
        .head       (head_reg),
        .valid      (valid_vec),
        .complete   (complete_vec),
        .retire_en  (retire_en),
        .retire_cnt (retire_cnt),
        .retire_idx (retire_idx)
    );

    always_comb begin
        rob_idx        wr_ptr;
        count_t        alloc_cnt;
        rob_row_struct row;

        entry_next       = entry_reg;
        err_next         = err_reg;
        retire_rows_next = '0;
        free_valid_next  = '0;
        free_addr_next   = '0;
        wr_ptr           = tail_reg;
        alloc_cnt        = '0;
        row              = '0;

        // Highest port first so the lowest-numbered port's write lands last.
        for (int p = CMPL_W - 1; p >= 0; p--) begin
            if (cmpl[p].valid) begin
                if (!entry_reg[cmpl[p].rob].valid) begin
                    err_next = 1'b1;
                end else begin
                    entry_next[cmpl[p].rob].complete = 1'b1;
                    entry_next[cmpl[p].rob].data     = cmpl[p].data;
                end
                for (int q = 0; q < p; q++) begin
                    if (cmpl[q].valid && (cmpl[q].rob == cmpl[p].rob))
                        err_next = 1'b1;
                end
            end
        end

        for (int k = 0; k < RETIRE_W; k++) begin
            if (retire_en[k]) begin
                retire_rows_next[k]         = entry_reg[retire_idx[k]];
                free_valid_next[k]          = frees_preg(entry_reg[retire_idx[k]]);
                free_addr_next[k]           = entry_reg[retire_idx[k]].old_preg_dst;
                entry_next[retire_idx[k]]   = '0;
            end
        end

        // Full is judged on the registered flag, so a same-cycle retire never
        // makes room for an allocation.
        for (int a = 0; a < ALLOC_W; a++) begin
            if (i_alloc_rows[a].valid) begin
                if (full_reg) begin
                    err_next = 1'b1;
                end else begin
                    row          = i_alloc_rows[a];
                    row.complete = 1'b0;
                    row.data     = '0;
                    if (row.rob_number != wr_ptr)
                        err_next = 1'b1;
                    entry_next[wr_ptr] = row;
                    wr_ptr             = wr_ptr + rob_idx'(1);
                    alloc_cnt          = alloc_cnt + count_t'(1);
                end
            end
        end

        tail_next  = wr_ptr;
        head_next  = head_reg + rob_idx'(retire_cnt);
        count_next = count_reg + alloc_cnt - count_t'(retire_cnt);
        full_next  = (count_t'(DEPTH) - count_next) < count_t'(ALLOC_W);
        empty_next = (count_next == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                entry_reg[i] <= '0;
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
            full_reg        <= 1'b0;
            empty_reg       <= 1'b1;
            err_reg         <= 1'b0;
            retire_rows_reg <= '0;
            free_valid_reg  <= '0;
            free_addr_reg   <= '0;
        end else begin
            entry_reg       <= entry_next;
            head_reg        <= head_next;
            tail_reg        <= tail_next;
            count_reg       <= count_next;
            full_reg        <= full_next;
            empty_reg       <= empty_next;
            err_reg         <= err_next;
            retire_rows_reg <= retire_rows_next;
            free_valid_reg  <= free_valid_next;
            free_addr_reg   <= free_addr_next;
        end
    end

    assign o_full            = full_reg;
    assign o_empty           = empty_reg;
    assign o_err             = err_reg;
    assign o_retire_rows     = retire_rows_reg;
    assign o_free_preg_valid = free_valid_reg;
    assign o_free_preg_addr  = free_addr_reg;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a queue-based program-order model and
// a per-cycle compare process on the falling edge.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic                 clk;
    logic                 rst_n;
    rob_row_struct [0:1]  alloc_rows;
    logic                 full, empty, err;
    logic [0:2]           cmpl_valid;
    rob_idx [0:2]         cmpl_rob;
    word [0:2]            cmpl_data;
    rob_row_struct [0:2]  retire_rows;
    logic [0:1]           free_valid;
    p_reg [0:1]           free_addr;

    int checks = 0;
    int errors = 0;

    reorder_buffer dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_alloc_rows      (alloc_rows),
        .o_full            (full),
        .o_empty           (empty),
        .i_cmpl_valid      (cmpl_valid),
        .i_cmpl_rob        (cmpl_rob),
        .i_cmpl_data       (cmpl_data),
        .o_retire_rows     (retire_rows),
        .o_free_preg_valid (free_valid),
        .o_free_preg_addr  (free_addr),
        .o_err             (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: in-flight rows in program order, each tagged with its landing slot.
    typedef struct {
        rob_idx        slot;
        rob_row_struct row;
    } m_ent_t;

    m_ent_t         q[$];
    rob_idx         m_tail;
    logic           m_err;
    rob_row_struct  exp_retire [3];
    logic [0:1]     exp_free_valid;
    p_reg           exp_free_addr [2];
    logic           exp_full, exp_empty, exp_err;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_tail = '0;
        m_err  = 1'b0;
        for (int k = 0; k < 3; k++) exp_retire[k] = '0;
        exp_free_valid = '0;
        exp_free_addr[0] = '0;
        exp_free_addr[1] = '0;
        exp_full  = 1'b0;
        exp_empty = 1'b1;
        exp_err   = 1'b0;
    endtask

    task automatic model_step();
        rob_row_struct ret [3];
        int            nret;
        bit            dup, found;
        m_ent_t        e;
        if (!rst_n) return;
        for (int k = 0; k < 3; k++) ret[k] = '0;
        nret = 0;
        for (int k = 0; k < 2; k++) begin
            if (q.size() > k && nret == k && q[k].row.complete) begin
                ret[k] = q[k].row;
                nret++;
            end
        end
        for (int p = 0; p < 3; p++) begin
            if (cmpl_valid[p]) begin
                dup = 0;
                for (int r = 0; r < p; r++)
                    if (cmpl_valid[r] && cmpl_rob[r] == cmpl_rob[p]) dup = 1;
                if (dup) m_err = 1'b1;
                found = 0;
                foreach (q[i]) begin
                    if (q[i].slot == cmpl_rob[p]) begin
                        found = 1;
                        if (!dup) begin
                            q[i].row.complete = 1'b1;
                            q[i].row.data     = cmpl_data[p];
                        end
                    end
                end
                if (!found) m_err = 1'b1;
            end
        end
        for (int a = 0; a < 2; a++) begin
            if (alloc_rows[a].valid) begin
                if (exp_full) begin
                    m_err = 1'b1;
                end else begin
                    e.slot = m_tail;
                    e.row  = alloc_rows[a];
                    e.row.complete = 1'b0;
                    e.row.data     = '0;
                    if (alloc_rows[a].rob_number != m_tail) m_err = 1'b1;
                    q.push_back(e);
                    m_tail = m_tail + rob_idx'(1);
                end
            end
        end
        repeat (nret) void'(q.pop_front());
        for (int k = 0; k < 3; k++) exp_retire[k] = ret[k];
        for (int k = 0; k < 2; k++) begin
            exp_free_valid[k] = ret[k].valid && ret[k].reg_write && (ret[k].old_preg_dst != 0);
            exp_free_addr[k]  = ret[k].old_preg_dst;
        end
        exp_full  = (16 - q.size()) < 2;
        exp_empty = (q.size() == 0);
        exp_err   = m_err;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("retire_row%0d", k), 64'(retire_rows[k]), 64'(exp_retire[k]));
            if (retire_rows[k].valid)
                $display("retire slot%0d rob=%0d data=%0h free=%0b", k,
                         retire_rows[k].rob_number, retire_rows[k].data, (k < 2) ? free_valid[k] : 1'b0);
        end
        check_eq("free_valid", 64'(free_valid), 64'(exp_free_valid));
        for (int k = 0; k < 2; k++)
            if (exp_free_valid[k])
                check_eq($sformatf("free_addr%0d", k), 64'(free_addr[k]), 64'(exp_free_addr[k]));
        check_eq("full", 64'(full), 64'(exp_full));
        check_eq("empty", 64'(empty), 64'(exp_empty));
        check_eq("err", 64'(err), 64'(exp_err));
    end

    function automatic rob_row_struct mkrow(input int rob, input int dst, input int old,
                                            input bit rw, input bit mw);
        rob_row_struct r;
        r              = '0;
        r.valid        = 1'b1;
        r.rob_number   = rob_idx'(rob);
        r.reg_write    = rw;
        r.mem_write    = mw;
        r.preg_dst     = p_reg'(dst);
        r.old_preg_dst = p_reg'(old);
        r.data         = word'(32'hDEAD0000 + rob);
        return r;
    endfunction

    function automatic rob_row_struct seqrow(input int rob);
        return mkrow(rob, 32 + rob, rob, (rob != 5), (rob == 5));
    endfunction

    task automatic idle();
        alloc_rows = '0;
        cmpl_valid = '0;
        cmpl_rob   = '0;
        cmpl_data  = '0;
    endtask

    task automatic set_cmpl(input int p, input int rob, input logic [31:0] d);
        cmpl_valid[p] = 1'b1;
        cmpl_rob[p]   = rob_idx'(rob);
        cmpl_data[p]  = d;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycle();
        step();
        idle();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        model_reset();
        idle();
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        model_reset();
        #1 rst_n = 1'b0;

        // Reset state
        repeat (2) step();
        check_eq("rst_empty", 64'(empty), 64'(1));
        check_eq("rst_full", 64'(full), 64'(0));
        check_eq("rst_err", 64'(err), 64'(0));
        check_eq("rst_retire_valid", 64'({retire_rows[0].valid, retire_rows[1].valid, retire_rows[2].valid}), 64'(0));
        rst_n = 1'b1;

        // Out-of-order completion, paired in-order retire
        alloc_rows[0] = mkrow(0, 33, 1, 1, 0);
        alloc_rows[1] = mkrow(1, 34, 2, 1, 0);
        cycle();
        cycle();
        set_cmpl(0, 1, 32'hBEEF);
        cycle();
        cycle();
        set_cmpl(0, 0, 32'hCAFE);
        cycle();
        check_eq("t2_no_early_retire", 64'(retire_rows[0].valid), 64'(0));
        cycle();
        check_eq("t2_both_valid", 64'({retire_rows[0].valid, retire_rows[1].valid}), 64'(2'b11));
        check_eq("t2_data0", 64'(retire_rows[0].data), 64'(32'hCAFE));
        check_eq("t2_data1", 64'(retire_rows[1].data), 64'(32'hBEEF));
        check_eq("t2_free_valid", 64'(free_valid), 64'(2'b11));
        check_eq("t2_free0", 64'(free_addr[0]), 64'(1));
        check_eq("t2_free1", 64'(free_addr[1]), 64'(2));
        cycle();
        check_eq("t2_held_one_cycle", 64'(retire_rows[0].valid), 64'(0));
        check_eq("t2_empty", 64'(empty), 64'(1));

        // Fill to 16, then overflow
        reset_pulse();
        for (int i = 0; i < 8; i++) begin
            alloc_rows[0] = seqrow(2 * i);
            alloc_rows[1] = seqrow(2 * i + 1);
            cycle();
            if (i == 6) check_eq("t3_full_at14", 64'(full), 64'(0));
        end
        check_eq("t3_full_at16", 64'(full), 64'(1));
        check_eq("t3_no_err", 64'(err), 64'(0));
        alloc_rows[0] = seqrow(0);
        alloc_rows[1] = seqrow(1);
        cycle();
        check_eq("t3_overflow_err", 64'(err), 64'(1));
        check_eq("t3_still_full", 64'(full), 64'(1));

        // Retire 14, then wrap the tail and retire across 15->0
        for (int c = 0; c < 5; c++) begin
            for (int p = 0; p < 3; p++)
                if (3 * c + p < 14) set_cmpl(p, 3 * c + p, 32'h100 + 3 * c + p);
            cycle();
        end
        repeat (6) cycle();
        check_eq("t4_full_cleared", 64'(full), 64'(0));
        check_eq("t4_not_empty", 64'(empty), 64'(0));
        alloc_rows[0] = seqrow(0);
        alloc_rows[1] = seqrow(1);
        cycle();
        alloc_rows[0] = seqrow(2);
        alloc_rows[1] = seqrow(3);
        cycle();
        set_cmpl(0, 14, 32'hE14);
        set_cmpl(1, 15, 32'hE15);
        set_cmpl(2, 0, 32'hE00);
        cycle();
        check_eq("t4_no_retire", 64'(retire_rows[0].valid), 64'(0));
        set_cmpl(0, 1, 32'hE01);
        cycle();
        check_eq("t4_rob14", 64'(retire_rows[0].rob_number), 64'(14));
        check_eq("t4_rob15", 64'(retire_rows[1].rob_number), 64'(15));
        set_cmpl(0, 2, 32'hE02);
        set_cmpl(1, 3, 32'hE03);
        cycle();
        check_eq("t4_rob0", 64'(retire_rows[0].rob_number), 64'(0));
        check_eq("t4_rob1", 64'(retire_rows[1].rob_number), 64'(1));
        cycle();
        check_eq("t4_rob2_data", 64'(retire_rows[0].data), 64'(32'hE02));
        check_eq("t4_empty", 64'(empty), 64'(1));

        // Same-cycle alloc + retire at count 14, then completion to an empty entry
        reset_pulse();
        for (int i = 0; i < 7; i++) begin
            alloc_rows[0] = seqrow(2 * i);
            alloc_rows[1] = seqrow(2 * i + 1);
            cycle();
        end
        set_cmpl(0, 0, 32'hA0);
        set_cmpl(1, 1, 32'hA1);
        cycle();
        alloc_rows[0] = seqrow(14);
        alloc_rows[1] = seqrow(15);
        cycle();
        check_eq("t5_retired_pair", 64'({retire_rows[0].valid, retire_rows[1].valid}), 64'(2'b11));
        check_eq("t5_full_at14", 64'(full), 64'(0));
        check_eq("t5_no_err", 64'(err), 64'(0));
        alloc_rows[0] = seqrow(0);
        alloc_rows[1] = seqrow(1);
        cycle();
        check_eq("t5_full_at16", 64'(full), 64'(1));
        check_eq("t5_no_err_after_wrap", 64'(err), 64'(0));
        set_cmpl(0, 2, 32'hA2);
        set_cmpl(1, 3, 32'hA3);
        cycle();
        cycle();
        check_eq("t5_err_clean", 64'(err), 64'(0));
        set_cmpl(0, 3, 32'hBAD);
        cycle();
        check_eq("t5_empty_cmpl_err", 64'(err), 64'(1));

        // Async reset with rows in flight
        reset_pulse();
        alloc_rows[0] = seqrow(0);
        alloc_rows[1] = seqrow(1);
        cycle();
        alloc_rows[0] = seqrow(2);
        alloc_rows[1] = seqrow(3);
        cycle();
        alloc_rows[1] = seqrow(4);
        cycle();
        set_cmpl(2, 0, 32'h55);
        cycle();
        cycle();
        check_eq("t6_pre_reset_retire", 64'(retire_rows[0].valid), 64'(1));
        rst_n = 1'b0;
        model_reset();
        #2;
        check_eq("t6_async_retire_clear", 64'(retire_rows[0].valid), 64'(0));
        check_eq("t6_async_empty", 64'(empty), 64'(1));
        repeat (2) step();
        rst_n = 1'b1;
        alloc_rows[0] = mkrow(0, 40, 0, 1, 0);
        cycle();
        check_eq("t6_realloc_no_err", 64'(err), 64'(0));
        check_eq("t6_realloc_not_empty", 64'(empty), 64'(0));
        set_cmpl(0, 0, 32'h1111);
        set_cmpl(1, 0, 32'h2222);
        cycle();
        check_eq("t6_dup_err", 64'(err), 64'(1));
        cycle();
        check_eq("t6_dup_low_port_wins", 64'(retire_rows[0].data), 64'(32'h1111));
        check_eq("t6_old_zero_no_free", 64'(free_valid), 64'(0));

        // ROBNumber mismatch still lands at tail
        reset_pulse();
        alloc_rows[0] = seqrow(5);
        cycle();
        check_eq("t7_mismatch_err", 64'(err), 64'(1));
        check_eq("t7_mismatch_written", 64'(empty), 64'(0));

        repeat (3) cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
